// File: rtl/frog_disp_pkg.sv
// frog_disp_pkg: shared constants for the frog position display
//   N_POS      number of frog positions (one-hot vector width)
//   GOAL_POS   position index of the goal square
//   SEG_BLANK  all segments off (active-low)
//   SEG_DASH   only segment g lit (active-low)
//   SEG_DIGITS active-low segment codes for digits 0..9
package frog_disp_pkg;
  localparam int N_POS = 19;
  localparam logic [4:0] GOAL_POS = 5'd18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_DIGITS [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
endpackage

// File: rtl/frog_pos_display_seg7_encode.sv
// seg7_encode: BCD digit to active-low 7-segment code
//   bcd  in  4  digit value; values above 9 render blank
//   seg  out 7  segments, bit0=a .. bit6=g, active-low
module seg7_encode
  import frog_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = (bcd > 4'd9) ? SEG_BLANK : SEG_DIGITS[bcd];
endmodule

// File: rtl/frog_pos_display.sv
// frog_pos_display: validates a one-hot frog vector and shows its position on a 2-digit display
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   frog       in   19-bit one-hot frog position
//   seg        out  active-low segments, bit0=a .. bit6=g
//   an         out  active-low digit enables, an[0]=ones, an[1]=tens
//   pos        out  binary position of the last valid vector
//   pos_valid  out  current vector is exactly one-hot
//   goal       out  one-cycle pulse on entering the goal square
//   err        out  current vector is zero or multi-hot
module frog_pos_display
  import frog_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_POS-1:0] frog,
  output logic [6:0]       seg,
  output logic [1:0]       an,
  output logic [4:0]       pos,
  output logic             pos_valid,
  output logic             goal,
  output logic             err
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);
  logic [N_POS-1:0] frog_q;
  logic [4:0] idx;
  logic one_hot;
  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blink_cnt;
  logic digit_sel, blink_on, at_goal_q;
  logic at_goal, wrap, bwrap, dsel_n, blink_n, tens;
  logic [3:0] ones, bcd;
  logic [6:0] enc, seg_n;
  // Input capture is deliberately unreset; an unknown vector simply decodes as invalid.
  always_ff @(posedge clk) frog_q <= frog;
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_POS; i++) if (frog_q[i]) idx = 5'(i);
  end
  assign one_hot = $onehot(frog_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos <= '0;
      pos_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      pos_valid <= one_hot;
      err <= !one_hot;
      if (one_hot) pos <= idx;
    end
  assign at_goal = pos_valid && pos == GOAL_POS;
  assign tens = pos >= 5'd10;
  assign ones = 4'(pos - (tens ? 5'd10 : 5'd0));
  assign wrap = ref_cnt == R_MAX;
  assign bwrap = blink_cnt == B_MAX;
  // seg/an are driven from next-state select and blink so both change on the same edge.
  assign dsel_n = digit_sel ^ wrap;
  assign blink_n = at_goal ? blink_on ^ bwrap : 1'b1;
  assign bcd = dsel_n ? (tens ? 4'd1 : 4'hF) : ones;
  seg7_encode u_enc (.bcd(bcd), .seg(enc));
  assign seg_n = pos_valid ? enc : SEG_DASH;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ref_cnt <= '0;
      digit_sel <= 1'b0;
      blink_cnt <= '0;
      blink_on <= 1'b1;
      at_goal_q <= 1'b0;
      goal <= 1'b0;
      seg <= SEG_BLANK;
      an <= 2'b11;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
      digit_sel <= dsel_n;
      blink_cnt <= (at_goal && !bwrap) ? blink_cnt + 1'b1 : '0;
      blink_on <= blink_n;
      at_goal_q <= at_goal;
      goal <= at_goal && !at_goal_q;
      seg <= seg_n;
      an <= !blink_n ? 2'b11 : dsel_n ? 2'b01 : 2'b10;
    end
endmodule

// File: tb/tb_frog_pos_display.sv
// tb_frog_pos_display: directed plus randomized checks of frog_pos_display against an edge-count reference model
module tb_frog_pos_display;
  localparam int R = 4;
  localparam int B = 8;
  localparam logic [18:0] GOAL_V = 19'h40000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [18:0] frog = '0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [4:0] pos;
  logic pos_valid, goal, err;
  int tests = 0;
  int fails = 0;
  int k = 0;
  int c = 0;
  int mpos = 0;
  int ppos = 0;
  logic [18:0] h [4] = '{default: '0};
  logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic e_dsel, e_blink;

  frog_pos_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .frog(frog), .seg(seg), .an(an), .pos(pos),
    .pos_valid(pos_valid), .goal(goal), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit valid(input logic [18:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at k=%0d", tag, got, exp, k);
    end
  endtask

  task automatic chk_reset();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h3);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_pv", 32'(pos_valid), 0);
    chk("rst_goal", 32'(goal), 0);
    chk("rst_err", 32'(err), 0);
  endtask

  // Model: after edge k, outputs are functions of edge count and the sampled frog history.
  task automatic tick();
    logic pv_prev;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    @(posedge clk);
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = frog;
    if (rst) begin
      k = 0; c = 0; mpos = 0; ppos = 0;
    end else begin
      k++;
      ppos = mpos;
      if (k >= 2 && h[2] == GOAL_V) c++; else c = 0;
      if (valid(h[1])) mpos = $clog2(h[1]);
    end
    @(negedge clk);
    if (k == 0) chk_reset();
    else begin
      e_dsel = ((k / R) % 2) == 1;
      e_blink = ((c / B) % 2) == 0;
      pv_prev = k >= 2 && valid(h[2]);
      e_seg = !pv_prev ? 7'h3F : e_dsel ? (ppos >= 10 ? tab[1] : 7'h7F) : tab[ppos % 10];
      e_an = !e_blink ? 2'b11 : e_dsel ? 2'b01 : 2'b10;
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("pos", 32'(pos), 32'(mpos));
      chk("pos_valid", 32'(pos_valid), 32'(valid(h[1])));
      chk("err", 32'(err), 32'(!valid(h[1])));
      chk("goal", 32'(goal), 32'(k >= 2 && h[2] == GOAL_V && !(k >= 3 && h[3] == GOAL_V)));
    end
  endtask

  task automatic run(input logic [18:0] f, input int n);
    frog = f;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int a, n, sel;
    logic [18:0] v;
    run('0, 4);
    rst = 1'b0;
    run('0, 12);
    run(19'h00001, 10);
    run(19'(1) << 13, 10);
    run(19'(1) << 9, 10);
    run(19'(1) << 13, 4);
    run(19'h00006, 8);
    run(19'(1) << 13, 8);
    run(GOAL_V, 40);
    run(19'(1) << 17, 12);
    run(GOAL_V, 20);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 4);
      a = $urandom_range(0, 17);
      n = $urandom_range(1, 12);
      v = sel == 0 ? 19'h0 :
          sel == 1 ? (19'($urandom) | (19'(1) << a) | (19'(2) << a)) :
          sel == 2 ? GOAL_V : (19'(1) << $urandom_range(0, 18));
      run(v, n);
    end
    frog = GOAL_V;
    for (int i = 0; i < 64 && !(e_dsel && !e_blink && k > 0 && c > 0); i++) tick();
    chk("pre_async_state", 32'({e_dsel, e_blink}), 32'b10);
    #2 rst = 1'b1;
    #1 chk_reset();
    run(GOAL_V, 3);
    rst = 1'b0;
    run(GOAL_V, 30);
    run(19'h00010, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
